// File: rtl/riscv_multicycle_ctrl.sv
// Moore control FSM for a shared-datapath multicycle RISC-V core; only handshake/branch terms are Mealy.
// Optional retired-instruction counter enabled by defining RISCV_INSTRET_EN.
module riscv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             adr_src,
  output logic             illegal,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // fetch/beq/jal/decode flags qualify the Mealy pc_write, ir_write and illegal terms
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       fetch;
    logic       decode;
    logic       beq;
    logic       jal;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [1:0] res;
  } ctl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t state_r;
  state_t next_state_s;
  ctl_t   ctl_r;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: is_legal = 1'b1;
      default:                                               is_legal = 1'b0;
    endcase
  endfunction

  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.fetch = 1'b1; c.mem_read = 1'b1; c.b = 2'b10; c.res = 2'b10; end
      S_DECODE:   begin c.decode = 1'b1; c.a = 2'b01; c.b = 2'b01; end
      S_MEMADR:   begin c.a = 2'b10; c.b = 2'b01; end
      S_MEMREAD:  begin c.mem_read = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.reg_write = 1'b1; c.res = 2'b01; end
      S_MEMWRITE: begin c.mem_write = 1'b1; c.adr_src = 1'b1; end
      S_EXECR:    begin c.a = 2'b10; c.b = 2'b00; c.op = 2'b10; end
      S_EXECI:    begin c.a = 2'b10; c.b = 2'b01; c.op = 2'b10; end
      S_ALUWB:    begin c.reg_write = 1'b1; c.res = 2'b00; end
      S_BEQ:      begin c.beq = 1'b1; c.a = 2'b10; c.b = 2'b00; c.op = 2'b01; end
      S_JAL:      begin c.jal = 1'b1; c.a = 2'b01; c.b = 2'b10; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // next-state selection; memory states hold until the transfer completes
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECR;
          OP_ITYPE:          next_state_s = S_EXECI;
          OP_BEQ:            next_state_s = S_BEQ;
          OP_JAL:            next_state_s = S_JAL;
          default:           next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state_s = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state_s = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state_s = S_ALUWB;
      S_EXECI:    next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BEQ:      next_state_s = S_FETCH;
      S_JAL:      next_state_s = S_ALUWB;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // state register with Moore controls decoded one edge early so they leave the flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      ctl_r   <= decode_ctl(S_FETCH);
    end else begin
      state_r <= next_state_s;
      ctl_r   <= decode_ctl(next_state_s);
    end
  end

  assign state      = state_r;
  assign adr_src    = ctl_r.adr_src;
  assign alu_src_a  = ctl_r.a;
  assign alu_src_b  = ctl_r.b;
  assign alu_op     = ctl_r.op;
  assign result_src = ctl_r.res;
  // write and strobe controls are held inactive for as long as reset is asserted
  assign mem_read   = ~reset & ctl_r.mem_read;
  assign mem_write  = ~reset & ctl_r.mem_write;
  assign reg_write  = ~reset & ctl_r.reg_write;
  assign ir_write   = ~reset & ctl_r.fetch & mem_ready;
  assign pc_write   = ~reset & ((ctl_r.fetch & mem_ready) | (ctl_r.beq & zero) | ctl_r.jal);
  assign illegal    = ~reset & ctl_r.decode & ~is_legal(opcode);

`ifdef RISCV_INSTRET_EN
  logic [CNT_W-1:0] instret_r;
  logic             retire_s;

  // an instruction retires on the edge that leaves its final state
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_MEMWB, S_ALUWB, S_BEQ: retire_s = 1'b1;
      S_MEMWRITE:              retire_s = mem_ready;
      default:                 retire_s = 1'b0;
    endcase
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret = instret_r;
`else
  assign instret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized and directed bench for riscv_multicycle_ctrl against a per-instruction state-path model.
module tb_riscv_multicycle_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, zero, mem_ready;
  logic [6:0]   opcode;
  logic         pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, illegal;
  logic [1:0]   alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0]   state;
  logic [W-1:0] instret;

  int           compared = 0;
  int           mismatched = 0;
  logic [W-1:0] exp_instret;

`ifdef RISCV_INSTRET_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  riscv_multicycle_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src), .illegal(illegal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [6:0] op);
    return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
           (op == 7'b0010011) || (op == 7'b1100011) || (op == 7'b1101111);
  endfunction

  // {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, illegal, a, b, op, res}
  function automatic logic [14:0] exp_out(input int s, input logic mr, input logic z, input logic [6:0] op);
    logic pc, ir, rw, rd, wr, adr, ill;
    logic [1:0] a, b, aop, res;
    {pc, ir, rw, rd, wr, adr, ill} = 7'b0;
    {a, b, aop, res} = 8'b0;
    case (s)
      0:  begin rd = 1'b1; b = 2'b10; res = 2'b10; ir = mr; pc = mr; end
      1:  begin a = 2'b01; b = 2'b01; ill = ~legal(op); end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin rd = 1'b1; adr = 1'b1; end
      4:  begin res = 2'b01; rw = 1'b1; end
      5:  begin wr = 1'b1; adr = 1'b1; end
      6:  begin a = 2'b10; b = 2'b00; aop = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      8:  begin res = 2'b00; rw = 1'b1; end
      9:  begin a = 2'b10; b = 2'b00; aop = 2'b01; pc = z; end
      10: begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      default: ;
    endcase
    return {pc, ir, rw, rd, wr, adr, ill, a, b, aop, res};
  endfunction

  // Runs one instruction from FETCH; fw/mw = wait cycles in fetch / data-memory states.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input logic z);
    int seq[$];
    bit retires;
    int waits;
    retires = 1'b1;
    case (opc)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 8};
      7'b0010011: seq = '{0, 1, 7, 8};
      7'b1100011: seq = '{0, 1, 9};
      7'b1101111: seq = '{0, 1, 10, 8};
      default: begin seq = '{0, 1}; retires = 1'b0; end
    endcase
    foreach (seq[i]) begin
      waits = (seq[i] == 0) ? fw : ((seq[i] == 3 || seq[i] == 5) ? mw : 0);
      for (int k = 0; k <= waits; k++) begin
        opcode = opc;
        zero = z;
        mem_ready = (k == waits);
        #2;
        check("state", 32'(state), 32'(seq[i]));
        check("outputs", 32'({pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, illegal,
                              alu_src_a, alu_src_b, alu_op, result_src}),
              32'(exp_out(seq[i], mem_ready, z, opc)));
        @(posedge clk);
        #1;
      end
    end
    if (retires && CNT_ON) exp_instret = exp_instret + 4'd1;
    check("instret", 32'(instret), 32'(exp_instret));
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [6:0] pick;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000, 7'b1111111};
    reset = 1'b1; opcode = 7'b0; zero = 1'b0; mem_ready = 1'b1;
    exp_instret = 4'd0;

    // reset held two cycles: controls forced low even with mem_ready high
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", 32'({pc_write, ir_write, reg_write, mem_read, mem_write, illegal}), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    reset = 1'b0;

    run_instr(7'b0110011, 0, 0, 1'b0);
    run_instr(7'b0000011, 0, 3, 1'b0);
    run_instr(7'b1100011, 0, 0, 1'b1);
    run_instr(7'b1100011, 0, 0, 1'b0);
    run_instr(7'b0000000, 0, 0, 1'b0);
    run_instr(7'b0100011, 2, 2, 1'b0);
    run_instr(7'b0010011, 1, 0, 1'b1);
    run_instr(7'b1101111, 0, 0, 1'b0);

    repeat (60) begin
      pick = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) pick = 7'($urandom);
      run_instr(pick, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    // reset while a store is stalled in MEMWRITE
    opcode = 7'b0100011; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #1;
    check("sw_wait_state", 32'(state), 32'd5);
    check("sw_wait_wr", 32'({mem_write, adr_src}), 32'd3);
    @(posedge clk); #1;
    check("sw_hold_state", 32'(state), 32'd5);
    reset = 1'b1;
    #1;
    check("rst_mid_wr", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_instret", 32'(instret), 32'd0);
    check("rst_mid_wr2", 32'(mem_write), 32'd0);
    reset = 1'b0;
    exp_instret = 4'd0;

    // sixteen retirements wrap a 4-bit counter back to zero
    repeat (16) run_instr(7'b0110011, 0, 0, 1'b0);
    check("wrap_instret", 32'(instret), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
